// File: rtl/nibbler_fetch_unit.sv
// rtl/nibbler_fetch_unit.sv - Nibbler instruction fetch sequencer: PC, ROM req/ack, opcode/operand split
// Optional fetch timeout with sticky FAULT state is enabled by defining NIBBLER_FETCH_TIMEOUT_EN.
module nibbler_fetch_unit #(
  parameter int                ADDR_W         = 12,
  parameter logic [ADDR_W-1:0] RESET_PC       = '0,
  parameter int                TIMEOUT_CYCLES = 15
) (
  input  logic              clk,
  input  logic              reset,
  output logic              mem_req,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic              mem_ack,
  input  logic [7:0]        mem_data,
  output logic              instr_valid,
  input  logic              instr_ready,
  output logic [3:0]        instr_opcode,
  output logic [3:0]        instr_operand,
  output logic [ADDR_W-1:0] instr_pc,
  input  logic              jump_en,
  input  logic [ADDR_W-1:0] jump_addr,
  input  logic              halt,
  output logic              busy,
  output logic              fault
);

`ifdef NIBBLER_FETCH_TIMEOUT_EN
  typedef enum logic [1:0] {S_IDLE, S_FETCH, S_HOLD, S_FAULT} state_t;
`else
  typedef enum logic [1:0] {S_IDLE, S_FETCH, S_HOLD} state_t;
`endif

  state_t            r_state;
  logic [ADDR_W-1:0] r_pc;
  logic              r_mem_req;
  logic [ADDR_W-1:0] r_mem_addr;
  logic              r_instr_valid;
  logic [3:0]        r_opcode;
  logic [3:0]        r_operand;
  logic [ADDR_W-1:0] r_instr_pc;
  logic              r_flush;
  logic [ADDR_W-1:0] w_next_pc;
  logic              w_timeout;

  // A jump in the same cycle as a new request must redirect that request.
  assign w_next_pc = jump_en ? jump_addr : r_pc;

`ifdef NIBBLER_FETCH_TIMEOUT_EN
  localparam int WAIT_W = ($clog2(TIMEOUT_CYCLES) < 4) ? 4 : $clog2(TIMEOUT_CYCLES);
  localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(TIMEOUT_CYCLES - 1);

  logic              r_fault;
  logic [WAIT_W-1:0] r_wait;

  always_ff @(posedge clk) begin
    if (reset || r_state != S_FETCH || !r_mem_req || mem_ack) begin
      r_wait <= '0;
    end else if (r_wait != WAIT_LAST) begin
      r_wait <= r_wait + WAIT_W'(1);
    end
  end

  assign w_timeout = (r_state == S_FETCH) && r_mem_req && !mem_ack && (r_wait == WAIT_LAST);
  assign fault     = r_fault;
`else
  assign w_timeout = 1'b0;
  assign fault     = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state       <= S_IDLE;
      r_pc          <= RESET_PC;
      r_mem_req     <= 1'b0;
      r_mem_addr    <= '0;
      r_instr_valid <= 1'b0;
      r_opcode      <= 4'h0;
      r_operand     <= 4'h0;
      r_instr_pc    <= '0;
      r_flush       <= 1'b0;
`ifdef NIBBLER_FETCH_TIMEOUT_EN
      r_fault       <= 1'b0;
`endif
    end else begin
      if (jump_en) begin
        r_pc <= jump_addr;
      end
      case (r_state)
        S_IDLE: begin
          if (!halt) begin
            r_state    <= S_FETCH;
            r_mem_req  <= 1'b1;
            r_mem_addr <= w_next_pc;
          end
        end
        S_FETCH: begin
          if (!r_mem_req) begin
            // Gap cycle after a discarded byte: reissue at the (possibly new) PC.
            r_mem_req  <= 1'b1;
            r_mem_addr <= w_next_pc;
          end else if (mem_ack) begin
            if (r_flush || jump_en) begin
              r_flush   <= 1'b0;
              r_mem_req <= 1'b0;
              if (halt) begin
                r_state <= S_IDLE;
              end
            end else begin
              r_opcode      <= mem_data[7:4];
              r_operand     <= mem_data[3:0];
              r_instr_pc    <= r_pc;
              r_pc          <= r_pc + ADDR_W'(1);
              r_instr_valid <= 1'b1;
              r_mem_req     <= 1'b0;
              r_state       <= S_HOLD;
            end
          end else if (w_timeout) begin
            r_mem_req <= 1'b0;
            r_flush   <= 1'b0;
`ifdef NIBBLER_FETCH_TIMEOUT_EN
            r_fault   <= 1'b1;
            r_state   <= S_FAULT;
`endif
          end else if (jump_en) begin
            r_flush <= 1'b1;
          end
        end
        S_HOLD: begin
          // A jump with ready low drops the offered instruction; with ready high it completes first.
          if (instr_ready || jump_en) begin
            r_instr_valid <= 1'b0;
            if (halt) begin
              r_state <= S_IDLE;
            end else begin
              r_state    <= S_FETCH;
              r_mem_req  <= 1'b1;
              r_mem_addr <= w_next_pc;
            end
          end
        end
        default: begin
          r_mem_req     <= 1'b0;
          r_instr_valid <= 1'b0;
        end
      endcase
    end
  end

  assign mem_req       = r_mem_req;
  assign mem_addr      = r_mem_addr;
  assign instr_valid   = r_instr_valid;
  assign instr_opcode  = r_opcode;
  assign instr_operand = r_operand;
  assign instr_pc      = r_instr_pc;
  assign busy          = (r_state != S_IDLE);

endmodule

// File: tb/tb_nibbler_fetch_unit.sv
// tb/tb_nibbler_fetch_unit.sv - scoreboard bench for nibbler_fetch_unit with randomized ROM, stalls and jumps
module tb_nibbler_fetch_unit;
  localparam int ADDR_W = 12;

  logic              clk = 1'b0;
  logic              reset = 1'b1;
  logic              mem_req;
  logic [ADDR_W-1:0] mem_addr;
  logic              mem_ack = 1'b0;
  logic [7:0]        mem_data = 8'h00;
  logic              instr_valid;
  logic              instr_ready = 1'b0;
  logic [3:0]        instr_opcode;
  logic [3:0]        instr_operand;
  logic [ADDR_W-1:0] instr_pc;
  logic              jump_en = 1'b0;
  logic [ADDR_W-1:0] jump_addr = '0;
  logic              halt = 1'b1;
  logic              busy;
  logic              fault;

  nibbler_fetch_unit #(.ADDR_W(ADDR_W), .RESET_PC(12'h000), .TIMEOUT_CYCLES(15)) dut (
    .clk(clk), .reset(reset),
    .mem_req(mem_req), .mem_addr(mem_addr), .mem_ack(mem_ack), .mem_data(mem_data),
    .instr_valid(instr_valid), .instr_ready(instr_ready),
    .instr_opcode(instr_opcode), .instr_operand(instr_operand), .instr_pc(instr_pc),
    .jump_en(jump_en), .jump_addr(jump_addr), .halt(halt),
    .busy(busy), .fault(fault)
  );

  always #5 clk = ~clk;

  int n_pass = 0;
  int n_total = 0;
  int n_handshakes = 0;

  logic [7:0] rom [0:(1<<ADDR_W)-1];
  bit mem_en = 1'b1;
  int dly_lo = 0;
  int dly_hi = 0;

  typedef struct {
    logic [ADDR_W-1:0] pc;
    logic [7:0]        byt;
  } exp_t;
  exp_t q_exp[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_valid(input string name, input int bound);
    int k = 0;
    while (!instr_valid && k < bound) begin
      tick();
      k++;
    end
    check(name, instr_valid, 1'b1);
  endtask

  // Program ROM: acks after a random number of wait cycles, checks address stability.
  initial begin
    bit pending = 1'b0;
    int cnt = 0;
    bit prev_req = 1'b0;
    logic [ADDR_W-1:0] prev_addr = '0;
    forever begin
      tick();
      if (prev_req && !mem_ack && mem_req) check("mem_addr_stable", mem_addr, prev_addr);
      if (mem_ack) begin
        mem_ack  = 1'b0;
        mem_data = 8'($urandom);
        pending  = 1'b0;
      end else if (!mem_req) begin
        pending = 1'b0;
      end else if (mem_en) begin
        if (!pending) begin
          pending = 1'b1;
          cnt = $urandom_range(dly_hi, dly_lo);
        end
        if (cnt == 0) begin
          mem_ack  = 1'b1;
          mem_data = rom[mem_addr];
        end else begin
          cnt--;
        end
      end
      prev_req  = mem_req;
      prev_addr = mem_addr;
    end
  end

  // Reference model: instructions are delivered in PC order from the ROM; a jump
  // restarts the stream at its target, after any instruction accepted that same cycle.
  initial begin
    logic [ADDR_W-1:0] model_pc = '0;
    forever begin
      @(negedge clk);
      if (reset) begin
        model_pc = 12'h000;
      end else begin
        if (instr_valid && instr_ready) begin
          q_exp.push_back('{pc: model_pc, byt: rom[model_pc]});
          model_pc = model_pc + 12'h001;
        end
        if (jump_en) model_pc = jump_addr;
      end
    end
  end

  // Monitor: compares every accepted instruction against the scoreboard.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      #1;
      if (!reset && instr_valid && instr_ready) begin
        n_handshakes++;
        check("sb_pending", (q_exp.size() > 0), 1'b1);
        if (q_exp.size() > 0) begin
          e = q_exp.pop_front();
          check("sb_pc", instr_pc, e.pc);
          check("sb_opcode", instr_opcode, e.byt[7:4]);
          check("sb_operand", instr_operand, e.byt[3:0]);
        end
      end
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached, got running, expected finished");
    $fatal(1);
  end

  initial begin
    logic [3:0]        h_op;
    logic [3:0]        h_opr;
    logic [ADDR_W-1:0] h_pc;
    int                n;

    for (int i = 0; i < (1 << ADDR_W); i++) rom[i] = 8'($urandom);
    rom[0] = 8'h3A;

    tick();
    tick();
    check("rst_mem_req", mem_req, 1'b0);
    check("rst_valid", instr_valid, 1'b0);
    check("rst_busy", busy, 1'b0);
    check("rst_fault", fault, 1'b0);
    check("rst_mem_addr", mem_addr, 12'h000);
    check("rst_instr", {instr_opcode, instr_operand, instr_pc}, 20'h0);

    reset = 1'b0;
    tick();
    check("idle_halted_req", mem_req, 1'b0);
    halt = 1'b0;
    tick();
    check("first_req", mem_req, 1'b1);
    check("first_addr", mem_addr, 12'h000);
    check("first_busy", busy, 1'b1);
    tick();
    check("first_valid", instr_valid, 1'b1);
    check("first_opcode", instr_opcode, 4'h3);
    check("first_operand", instr_operand, 4'hA);
    check("first_pc", instr_pc, 12'h000);

    // Backpressure
    h_op = instr_opcode; h_opr = instr_operand; h_pc = instr_pc;
    for (int i = 0; i < 5; i++) begin
      tick();
      check("bp_hold", {instr_valid, mem_req, instr_opcode, instr_operand, instr_pc},
            {1'b1, 1'b0, h_op, h_opr, h_pc});
    end
    instr_ready = 1'b1;
    tick();
    instr_ready = 1'b0;
    check("bp_release_valid", instr_valid, 1'b0);
    check("bp_next_req", mem_req, 1'b1);
    check("bp_next_addr", mem_addr, 12'h001);
    wait_valid("second_valid", 10);
    check("second_pc", instr_pc, 12'h001);

    // Jump while a fetch is waiting on memory
    dly_lo = 3; dly_hi = 3;
    instr_ready = 1'b1;
    tick();
    instr_ready = 1'b0;
    check("jf_req", mem_req, 1'b1);
    jump_en = 1'b1; jump_addr = 12'h040;
    tick();
    jump_en = 1'b0;
    check("jf_keeps_req", mem_req, 1'b1);
    check("jf_keeps_addr", mem_addr, 12'h002);
    wait_valid("jf_valid", 40);
    check("jf_pc", instr_pc, 12'h040);

    // Jump in HOLD with ready low drops the instruction; then wrap through 0xFFF
    dly_lo = 0; dly_hi = 0;
    jump_en = 1'b1; jump_addr = 12'hFFF;
    tick();
    jump_en = 1'b0;
    check("jh_drop_valid", instr_valid, 1'b0);
    check("jh_addr", mem_addr, 12'hFFF);
    wait_valid("wrap_valid0", 10);
    check("wrap_pc0", instr_pc, 12'hFFF);
    instr_ready = 1'b1;
    tick();
    instr_ready = 1'b0;
    wait_valid("wrap_valid1", 10);
    check("wrap_pc1", instr_pc, 12'h000);

    // Halt never drops an offered instruction; takes effect at the handshake
    halt = 1'b1;
    for (int i = 0; i < 3; i++) tick();
    check("halt_keeps_instr", instr_valid, 1'b1);
    instr_ready = 1'b1;
    tick();
    instr_ready = 1'b0;
    check("halt_valid", instr_valid, 1'b0);
    check("halt_busy", busy, 1'b0);
    check("halt_req", mem_req, 1'b0);
    for (int i = 0; i < 3; i++) tick();
    check("halt_stays_idle", {busy, mem_req}, 2'b00);

    // Reset in the middle of a request
    halt = 1'b0;
    tick();
    check("pre_rst_req", mem_req, 1'b1);
    check("pre_rst_addr", mem_addr, 12'h001);
    reset = 1'b1;
    tick();
    check("mid_rst_req", mem_req, 1'b0);
    check("mid_rst_valid", instr_valid, 1'b0);
    check("mid_rst_busy", busy, 1'b0);
    reset = 1'b0;
    wait_valid("post_rst_valid", 10);
    check("post_rst_pc", instr_pc, 12'h000);

    // Randomized traffic
    dly_lo = 0; dly_hi = 3;
    for (int i = 0; i < 3000; i++) begin
      instr_ready = ($urandom_range(0, 3) != 0);
      jump_en     = ($urandom_range(0, 15) == 0);
      jump_addr   = 12'($urandom);
      if ($urandom_range(0, 31) == 0) halt = ~halt;
      tick();
    end
    jump_en = 1'b0; halt = 1'b0; instr_ready = 1'b1;
    for (int i = 0; i < 20; i++) tick();
    check("random_progress", (n_handshakes > 200), 1'b1);
    check("sb_drained", q_exp.size(), 0);

    // Memory that never answers
    reset = 1'b1; instr_ready = 1'b0;
    tick();
    reset = 1'b0; mem_en = 1'b0;
    tick();
    n = 0;
    while (mem_req && n < 40) begin
      n++;
      tick();
    end
`ifdef NIBBLER_FETCH_TIMEOUT_EN
    check("to_req_cycles", n, 15);
    check("to_fault", fault, 1'b1);
    check("to_busy", busy, 1'b1);
    check("to_valid", instr_valid, 1'b0);
    jump_en = 1'b1; jump_addr = 12'h123;
    tick();
    jump_en = 1'b0;
    for (int i = 0; i < 5; i++) tick();
    check("to_fault_sticky", {fault, mem_req, busy}, 3'b101);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    check("to_fault_cleared", fault, 1'b0);
`else
    check("no_to_req_held", n, 40);
    check("no_to_req", mem_req, 1'b1);
    check("no_to_fault", fault, 1'b0);
`endif

    mem_en = 1'b1;
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
